mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port synchronous memory block (registered read, write-enable gated, with output path delay) between two independent masters. It sits directly in front of the memory instance. Each cycle it selects at most one request, drives the memory's Addr/DataIn/WE, and returns read data tagged with the owning requester two cycles later. Back-to-back accesses run at full throughput.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_arb_if.sv | 37 +++
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Purpose: shared constants for the two-requester memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: requester id encodings and the read response latency in cycles.
package mem_arb_pkg;

    localparam logic REQ_ID0    = 1'b0;
    localparam logic REQ_ID1    = 1'b1;
    localparam int   RD_LATENCY = 2;

endpackage

// File: rtl/mem_arb_if.sv
// Purpose: bundles the requester, response and memory-side signals of mem_port_arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold Req/Wr/Addr/Wdata until their Gnt is seen high.
// Modports: slave = arbiter side, master = requesters plus memory model (bench side).
interface mem_arb_if #(
    parameter int MEM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  Req0;
    logic                  Req1;
    logic                  Wr0;
    logic                  Wr1;
    logic [ADDR_WIDTH-1:0] Addr0;
    logic [ADDR_WIDTH-1:0] Addr1;
    logic [MEM_WIDTH-1:0]  Wdata0;
    logic [MEM_WIDTH-1:0]  Wdata1;
    logic                  Gnt0;
    logic                  Gnt1;
    logic                  RdValid;
    logic                  RdId;
    logic [MEM_WIDTH-1:0]  RdData;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic [MEM_WIDTH-1:0]  MemDataIn;
    logic                  MemWE;
    logic [MEM_WIDTH-1:0]  MemDout;

    modport slave (
        input  Req0, Req1, Wr0, Wr1, Addr0, Addr1, Wdata0, Wdata1, MemDout,
        output Gnt0, Gnt1, RdValid, RdId, RdData, MemAddr, MemDataIn, MemWE
    );

    modport master (
        output Req0, Req1, Wr0, Wr1, Addr0, Addr1, Wdata0, Wdata1, MemDout,
        input  Gnt0, Gnt1, RdValid, RdId, RdData, MemAddr, MemDataIn, MemWE
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Purpose: combinational two-way picker; at most one grant, never without its request.
// Latency: 0 cycles (pure combinational).
// Backpressure: a losing requester simply sees its Gnt low and keeps holding Req.
// Ports: Req0/Req1 requests, Last = id granted most recently, Gnt0/Gnt1 grants.
// Config: MEM_ARB_RR_EN defined -> ties go to the requester not equal to Last;
//         undefined -> requester 0 always wins ties and Last is ignored.
module mem_arb_pick (
    input  logic Req0,
    input  logic Req1,
    input  logic Last,
    output logic Gnt0,
    output logic Gnt1
);
    import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
    // On a tie, hand the port to whoever did not have it last.
    assign Gnt0 = Req0 & (~Req1 | (Last == REQ_ID1));
    assign Gnt1 = Req1 & (~Req0 | (Last == REQ_ID0));
`else
    logic unused_last;
    assign unused_last = Last;
    assign Gnt0        = Req0;
    assign Gnt1        = Req1 & ~Req0;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port synchronous memory between two requesters.
// Latency: grant same cycle; read accepted at edge E returns RdValid/RdData launched at E+1, seen at E+2.
// Backpressure: losing requester holds its request; one access per cycle, no stalls.
// Ports: Clk, Rst_n (async active-low); bus (mem_arb_if.slave) carries requests,
//        grants, tagged read response and the memory Addr/DataIn/WE/Dout pins.
// Config: MEM_ARB_RR_EN enables round-robin tie-break (Last register); default is fixed priority.
module mem_port_arbiter #(
    parameter int MEM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    mem_arb_if.slave    bus
);
    import mem_arb_pkg::*;

    logic pick_gnt0;
    logic pick_gnt1;
    logic gnt0;
    logic gnt1;
    logic last_id;
    logic rd_acc;

    // Read tracking pipeline: stage 1 = address presented, stage 2 = data captured.
    logic                 s1_vld_q, s1_vld_d;
    logic                 s1_id_q,  s1_id_d;
    logic                 s2_vld_q, s2_vld_d;
    logic                 s2_id_q,  s2_id_d;
    logic [MEM_WIDTH-1:0] rd_data_q, rd_data_d;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (pick_gnt0) begin
            last_d = REQ_ID0;
        end else if (pick_gnt1) begin
            last_d = REQ_ID1;
        end
    end

    // Resetting to 1 lets requester 0 win the first tie.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_q <= REQ_ID1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_id = last_q;
`else
    assign last_id = REQ_ID1;
`endif

    mem_arb_pick u_pick (
        .Req0 (bus.Req0),
        .Req1 (bus.Req1),
        .Last (last_id),
        .Gnt0 (pick_gnt0),
        .Gnt1 (pick_gnt1)
    );

    // Flops are held in reset anyway, so only the outward grants need the reset gate.
    assign gnt0     = pick_gnt0 & Rst_n;
    assign gnt1     = pick_gnt1 & Rst_n;
    assign bus.Gnt0 = gnt0;
    assign bus.Gnt1 = gnt1;

    // Memory pin mux; with no winner the memory does a dummy read of address 0.
    always_comb begin
        bus.MemAddr   = '0;
        bus.MemDataIn = '0;
        bus.MemWE     = 1'b0;
        if (gnt0) begin
            bus.MemAddr   = bus.Addr0;
            bus.MemDataIn = bus.Wdata0;
            bus.MemWE     = bus.Wr0;
        end else if (gnt1) begin
            bus.MemAddr   = bus.Addr1;
            bus.MemDataIn = bus.Wdata1;
            bus.MemWE     = bus.Wr1;
        end
    end

    assign rd_acc = (pick_gnt0 & ~bus.Wr0) | (pick_gnt1 & ~bus.Wr1);

    always_comb begin
        s1_vld_d  = rd_acc;
        s1_id_d   = pick_gnt1 ? REQ_ID1 : REQ_ID0;
        s2_vld_d  = s1_vld_q;
        s2_id_d   = s1_id_q;
        rd_data_d = rd_data_q;
        // MemDout is valid one edge after the memory registered the read.
        if (s1_vld_q) begin
            rd_data_d = bus.MemDout;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_id_q   <= REQ_ID0;
            s2_vld_q  <= 1'b0;
            s2_id_q   <= REQ_ID0;
            rd_data_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_id_q   <= s1_id_d;
            s2_vld_q  <= s2_vld_d;
            s2_id_q   <= s2_id_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.RdValid = s2_vld_q;
    assign bus.RdId    = s2_id_q;
    assign bus.RdData  = rd_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter with a behavioural single-port memory.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int MW = 8;
    localparam int AW = 8;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arb_if #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) bus ();

    mem_port_arbiter #(.MEM_WIDTH(MW), .ADDR_WIDTH(AW)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: write at the edge, registered read, output path delay.
    logic [MW-1:0] mem [0:255];
    logic [MW-1:0] dout_r;
    always @(posedge clk) begin
        if (bus.MemWE) mem[bus.MemAddr] <= bus.MemDataIn;
        dout_r <= mem[bus.MemAddr];
    end
    assign #3 bus.MemDout = dout_r;

    typedef struct {
        logic          r0, w0;
        logic [AW-1:0] a0;
        logic [MW-1:0] d0;
        logic          r1, w1;
        logic [AW-1:0] a1;
        logic [MW-1:0] d1;
        logic          g0, g1, we;
        logic [AW-1:0] ma;
        logic [MW-1:0] md;
        logic          rv, rid;
        logic [MW-1:0] rd;
    } vec_t;

    localparam int NV = 15;
    vec_t tv [NV];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
        input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
        input logic g0, input logic g1, input logic we, input logic [7:0] ma, input logic [7:0] md,
        input logic rv, input logic rid, input logic [7:0] rd);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.we = we; v.ma = ma; v.md = md;
        v.rv = rv; v.rid = rid; v.rd = rd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.Req0 = v.r0; bus.Wr0 = v.w0; bus.Addr0 = v.a0; bus.Wdata0 = v.d0;
        bus.Req1 = v.r1; bus.Wr1 = v.w1; bus.Addr1 = v.a1; bus.Wdata1 = v.d1;
    endtask

    task automatic drive_idle();
        drive(mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,8'h00));
    endtask

    initial begin
        // Columns: req0 wr0 addr0 wdata0 | req1 wr1 addr1 wdata1 | gnt0 gnt1 we maddr mdin | rdvld rdid rddata
        tv[0]  = mk(1,1,8'h10,8'hA5, 0,0,8'h00,8'h00, 1,0,1,8'h10,8'hA5, 0,0,8'h00);
        tv[1]  = mk(1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h10,8'h00, 0,0,8'h00);
        tv[2]  = mk(0,0,8'h00,8'h00, 1,1,8'h01,8'h11, 0,1,1,8'h01,8'h11, 0,0,8'h00);
        tv[3]  = mk(0,0,8'h00,8'h00, 1,1,8'h02,8'h22, 0,1,1,8'h02,8'h22, 1,0,8'hA5);
        tv[4]  = mk(1,0,8'h01,8'h00, 1,0,8'h02,8'h00, 1,0,0,8'h01,8'h00, 0,0,8'h00);
        tv[5]  = mk(1,0,8'h01,8'h00, 1,0,8'h02,8'h00, !RR,RR,0,(RR ? 8'h02 : 8'h01),8'h00, 0,0,8'h00);
        tv[6]  = mk(1,0,8'h01,8'h00, 1,0,8'h02,8'h00, 1,0,0,8'h01,8'h00, 1,0,8'h11);
        tv[7]  = mk(1,0,8'h01,8'h00, 1,0,8'h02,8'h00, !RR,RR,0,(RR ? 8'h02 : 8'h01),8'h00,
                    1,RR,(RR ? 8'h22 : 8'h11));
        tv[8]  = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 1,0,8'h11);
        tv[9]  = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 1,RR,(RR ? 8'h22 : 8'h11));
        tv[10] = mk(0,0,8'h00,8'h00, 1,1,8'h20,8'h3C, 0,1,1,8'h20,8'h3C, 0,0,8'h00);
        tv[11] = mk(1,0,8'h20,8'h00, 0,0,8'h00,8'h00, 1,0,0,8'h20,8'h00, 0,0,8'h00);
        tv[12] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,8'h00);
        tv[13] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 1,0,8'h3C);
        tv[14] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,8'h00);

        // Reset state, with a write request held to show grant/WE are forced low.
        drive(mk(1,1,8'h55,8'h77, 1,0,8'h66,8'h00, 0,0,0,8'h00,8'h00, 0,0,8'h00));
        #1;
        chk("rst_gnt0",    bus.Gnt0,    1'b0);
        chk("rst_gnt1",    bus.Gnt1,    1'b0);
        chk("rst_memwe",   bus.MemWE,   1'b0);
        chk("rst_memaddr", bus.MemAddr, 8'h00);
        chk("rst_rdvalid", bus.RdValid, 1'b0);
        chk("rst_rdid",    bus.RdId,    1'b0);
        chk("rst_rddata",  bus.RdData,  8'h00);
        repeat (2) @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        // Table: drive mid-cycle, check combinational outputs and the registered response.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            chk($sformatf("v%0d_gnt0", i),    bus.Gnt0,    tv[i].g0);
            chk($sformatf("v%0d_gnt1", i),    bus.Gnt1,    tv[i].g1);
            chk($sformatf("v%0d_memwe", i),   bus.MemWE,   tv[i].we);
            chk($sformatf("v%0d_memaddr", i), bus.MemAddr, tv[i].ma);
            chk($sformatf("v%0d_memdin", i),  bus.MemDataIn, tv[i].md);
            chk($sformatf("v%0d_rdvalid", i), bus.RdValid, tv[i].rv);
            if (tv[i].rv) begin
                chk($sformatf("v%0d_rdid", i),   bus.RdId,   tv[i].rid);
                chk($sformatf("v%0d_rddata", i), bus.RdData, tv[i].rd);
            end
        end

        // Reset one cycle after a read is accepted: the read must vanish.
        @(negedge clk);
        drive(mk(1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,8'h00));
        #1;
        chk("mid_gnt0", bus.Gnt0, 1'b1);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdvalid", bus.RdValid, 1'b0);
        chk("mid_rst_rdid",    bus.RdId,    1'b0);
        chk("mid_rst_rddata",  bus.RdData,  8'h00);
        chk("mid_rst_memwe",   bus.MemWE,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst_rdvalid%0d", k), bus.RdValid, 1'b0);
        end

        // First tie after reset goes to requester 0; the next one depends on mode.
        @(negedge clk);
        drive(mk(1,0,8'h01,8'h00, 1,0,8'h02,8'h00, 0,0,0,8'h00,8'h00, 0,0,8'h00));
        #1;
        chk("tie1_gnt0", bus.Gnt0, 1'b1);
        chk("tie1_gnt1", bus.Gnt1, 1'b0);
        @(negedge clk);
        #1;
        chk("tie2_gnt0", bus.Gnt0, !RR);
        chk("tie2_gnt1", bus.Gnt1, RR);
        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
